ahb_lite_req_arbiter: RTL and testbench



---
 rtl/ahb_lite_req_arbiter.sv | 171 +++++++++++++++++
 tb/tb_ahb_lite_req_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_req_arbiter.sv
`default_nettype none
// =============================================================================
// ahb_lite_req_arbiter: shares one AHB3-Lite master port among NREQ requesters.
// Define AHB_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
// Revision: 1.0
// =============================================================================
module ahb_lite_req_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*3-1:0]  req_size,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               HSEL,
  output logic               HWRITE,
  output logic [AW-1:0]      HADDR,
  output logic [1:0]         HTRANS,
  output logic [2:0]         HSIZE,
  output logic [2:0]         HBURST,
  output logic [3:0]         HPROT,
  output logic [DW-1:0]      HWDATA,
  input  logic               HREADY,
  input  logic [DW-1:0]      HRDATA,
  input  logic               HRESP
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t        state_q;
  logic [IW-1:0] owner_q;
  logic [DW-1:0] wdata_q;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [AW-1:0] win_addr;
  logic [2:0]    win_size;
  logic          win_write;
  logic [DW-1:0] win_wdata;
  logic          win_legal;

`ifdef AHB_ARB_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] last_q;

  // Search starts one past the last grant and wraps at NREQ.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && req_valid[IW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end
`endif

  assign win_addr  = req_addr[int'(win_idx)*AW +: AW];
  assign win_size  = req_size[int'(win_idx)*3 +: 3];
  assign win_write = req_write[win_idx];
  assign win_wdata = req_wdata[int'(win_idx)*DW +: DW];

  always_comb begin
    case (win_size)
      3'd0:    win_legal = 1'b1;
      3'd1:    win_legal = ~win_addr[0];
      3'd2:    win_legal = (win_addr[1:0] == 2'b00);
      default: win_legal = 1'b0;
    endcase
  end

  assign req_ready = (state_q == S_IDLE && win_found) ? (NREQ'(1) << win_idx) : '0;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      wdata_q   <= '0;
`ifndef AHB_ARB_FIXED_PRIO_EN
      last_q    <= IW'(NREQ - 1);
`endif
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      HSEL      <= 1'b0;
      HWRITE    <= 1'b0;
      HADDR     <= '0;
      HTRANS    <= TR_IDLE;
      HSIZE     <= 3'd0;
      HWDATA    <= '0;
    end else begin
      rsp_valid <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            owner_q <= win_idx;
`ifndef AHB_ARB_FIXED_PRIO_EN
            last_q  <= win_idx;
`endif
            if (win_legal) begin
              state_q <= S_ADDR;
              HSEL    <= 1'b1;
              HTRANS  <= TR_NONSEQ;
              HADDR   <= win_addr;
              HWRITE  <= win_write;
              HSIZE   <= win_size;
              wdata_q <= win_wdata;
            end else begin
              // Rejected commands never reach the bus.
              rsp_valid <= NREQ'(1) << win_idx;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            state_q <= S_DATA;
            HSEL    <= 1'b0;
            HTRANS  <= TR_IDLE;
            HWDATA  <= wdata_q;
          end
        end
        S_DATA: begin
          if (HREADY) begin
            state_q   <= S_IDLE;
            rsp_valid <= NREQ'(1) << owner_q;
            rsp_err   <= HRESP;
            rsp_rdata <= HWRITE ? '0 : HRDATA;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_req_arbiter.sv
`default_nettype none
// =============================================================================
// tb_ahb_lite_req_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model of ahb_lite_req_arbiter. Revision: 1.0
// =============================================================================
`timescale 1ns/1ps
module tb_ahb_lite_req_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   req_write;
  logic [NREQ*3-1:0] req_size;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              HSEL, HWRITE;
  logic [AW-1:0]     HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE, HBURST;
  logic [3:0]        HPROT;
  logic [DW-1:0]     HWDATA;
  logic              HREADY;
  logic [DW-1:0]     HRDATA;
  logic              HRESP;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int            owner;
    logic [AW-1:0] addr;
    bit            wr;
    logic [2:0]    sz;
    logic [DW-1:0] wd;
  } cmd_t;

  cmd_t          mq[$];
  cmd_t          mcmd[NREQ];
  bit            mpend[NREQ];
  logic [DW-1:0] mem[16];

  always #5 HCLK = ~HCLK;

  ahb_lite_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HWRITE(HWRITE), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  task automatic cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    req_size  = '0;
    req_wdata = '0;
  endtask

  task automatic set_cmd(input int i, input logic [AW-1:0] a, input bit w,
                         input logic [2:0] s, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_write[i]         = w;
    req_size[i*3 +: 3]   = s;
    req_wdata[i*DW +: DW] = d;
    req_valid[i]         = 1'b1;
  endtask

  // Runs one command as requester idx with a scripted slave; returns the
  // response and the accept-to-response latency (-1 if none arrived).
  task automatic xfer(input int idx, input logic [AW-1:0] a, input bit w,
                      input logic [2:0] s, input logic [DW-1:0] d,
                      input int waits, input bit err, input logic [DW-1:0] rd,
                      output int lat, output logic [NREQ-1:0] rv,
                      output logic [DW-1:0] rdat, output logic rerr);
    bit acc, indata, start_d, done;
    int c, acc_c, cnt;
    acc = 0; indata = 0; start_d = 0; done = 0;
    c = 0; acc_c = 0; cnt = 0;
    lat = -1; rv = '0; rdat = '0; rerr = 1'b0;
    set_cmd(idx, a, w, s, d);
    while (!done && c < 40) begin
      if (indata) begin
        if (cnt < waits) begin HREADY = 1'b0; HRESP = 1'b0; end
        else if (err && cnt == waits) begin HREADY = 1'b0; HRESP = 1'b1; end
        else begin HREADY = 1'b1; HRESP = err; HRDATA = rd; end
      end else begin
        HREADY = 1'b1; HRESP = 1'b0;
      end
      @(negedge HCLK);
      if (rsp_valid !== '0) begin
        done = 1; lat = c - acc_c; rv = rsp_valid; rdat = rsp_rdata; rerr = rsp_err;
      end
      if (!acc && req_ready[idx] === 1'b1) begin acc = 1; acc_c = c; end
      start_d = HSEL && HTRANS == 2'b10 && HREADY;
      if (indata) begin
        if (HREADY) indata = 0;
        else cnt++;
      end
      @(posedge HCLK);
      #1;
      if (acc) req_valid[idx] = 1'b0;
      if (start_d) begin indata = 1; cnt = 0; end
      c++;
    end
    req_valid[idx] = 1'b0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    clear_reqs();
    repeat (2) @(negedge HCLK);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++; if ({rsp_valid, rsp_rdata, rsp_err} !== '0) begin errors++; $display("FAIL reset_rsp: got %b/%h/%b expected all 0", rsp_valid, rsp_rdata, rsp_err); end
    checks++; if ({HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA} !== '0) begin errors++; $display("FAIL reset_bus: got sel %b addr %h trans %b wr %b size %h wdata %h expected all 0", HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA); end
    checks++; if (HBURST !== 3'b000 || HPROT !== 4'b0011) begin errors++; $display("FAIL reset_const: got burst %b prot %b expected 000 0011", HBURST, HPROT); end
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic test_single_write();
    set_cmd(0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
    @(negedge HCLK);
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL wr_accept: got %b expected 001", req_ready); end
    cycle();
    req_valid = '0;
    @(negedge HCLK);
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h10 || HSEL !== 1'b1 || HWRITE !== 1'b1) begin errors++; $display("FAIL wr_addr_phase: got trans %b addr %h sel %b wr %b expected 10 00000010 1 1", HTRANS, HADDR, HSEL, HWRITE); end
    cycle();
    @(negedge HCLK);
    checks++; if (HWDATA !== 32'hDEADBEEF || HTRANS !== 2'b00) begin errors++; $display("FAIL wr_data_phase: got wdata %h trans %b expected deadbeef 00", HWDATA, HTRANS); end
    cycle();
    @(negedge HCLK);
    checks++; if (rsp_valid !== 3'b001 || rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp: got valid %b err %b expected 001 0", rsp_valid, rsp_err); end
    cycle();
    @(negedge HCLK);
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL wr_rsp_pulse: got %b expected 000", rsp_valid); end
    cycle();
  endtask

  task automatic test_read_wait();
    int lat; logic [NREQ-1:0] rv; logic [DW-1:0] rd; logic re;
    xfer(1, 32'h20, 1'b0, 3'd2, '0, 2, 1'b0, 32'h12345678, lat, rv, rd, re);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rd_wait_latency: got %0d expected 5", lat); end
    checks++; if (rv !== 3'b010 || re !== 1'b0) begin errors++; $display("FAIL rd_wait_rsp: got valid %b err %b expected 010 0", rv, re); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL rd_wait_data: got %h expected 12345678", rd); end
  endtask

  task automatic test_contention();
    int seq[4];
    int exp_seq[4];
    int n, t;
`ifdef AHB_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    seq = '{-1, -1, -1, -1};
    n = 0; t = 0;
    set_cmd(0, 32'h0, 1'b0, 3'd2, '0);
    set_cmd(1, 32'h4, 1'b0, 3'd2, '0);
    HREADY = 1'b1; HRESP = 1'b0;
    while (n < 4 && t < 60) begin
      @(negedge HCLK);
      for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) seq[n] = i;
      if (req_ready !== '0) n++;
      t++;
      cycle();
    end
    req_valid = '0;
    repeat (4) cycle();
    checks++; if (n !== 4) begin errors++; $display("FAIL contention_count: got %0d expected 4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (seq[i] !== exp_seq[i]) begin errors++; $display("FAIL contention_order[%0d]: got %0d expected %0d", i, seq[i], exp_seq[i]); end
    end
  endtask

  task automatic test_misaligned();
    set_cmd(0, 32'h2, 1'b1, 3'd2, 32'h55);
    @(negedge HCLK);
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL mis_accept: got %b expected 001", req_ready); end
    cycle();
    req_valid = '0;
    @(negedge HCLK);
    checks++; if (HTRANS !== 2'b00 || HSEL !== 1'b0) begin errors++; $display("FAIL mis_no_bus: got trans %b sel %b expected 00 0", HTRANS, HSEL); end
    checks++; if (rsp_valid !== 3'b001 || rsp_err !== 1'b1) begin errors++; $display("FAIL mis_rsp: got valid %b err %b expected 001 1", rsp_valid, rsp_err); end
    cycle();
    @(negedge HCLK);
    checks++; if (rsp_valid !== 3'b000 || rsp_err !== 1'b1 || HTRANS !== 2'b00) begin errors++; $display("FAIL mis_after: got valid %b err %b trans %b expected 000 1 00", rsp_valid, rsp_err, HTRANS); end
    cycle();
  endtask

  task automatic test_slave_error();
    int lat; logic [NREQ-1:0] rv; logic [DW-1:0] rd; logic re;
    xfer(0, 32'h8, 1'b1, 3'd2, 32'hA5A5A5A5, 0, 1'b1, '0, lat, rv, rd, re);
    checks++; if (rv !== 3'b001 || re !== 1'b1 || lat !== 4) begin errors++; $display("FAIL slverr_rsp: got valid %b err %b lat %0d expected 001 1 4", rv, re, lat); end
    xfer(1, 32'hC, 1'b1, 3'd1, 32'h0000BEEF, 0, 1'b0, '0, lat, rv, rd, re);
    checks++; if (rv !== 3'b010 || re !== 1'b0 || lat !== 3 || rd !== '0) begin errors++; $display("FAIL slverr_next: got valid %b err %b lat %0d rdata %h expected 010 0 3 0", rv, re, lat, rd); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [NREQ-1:0] rv; logic [DW-1:0] rd; logic re;
    set_cmd(0, 32'h30, 1'b1, 3'd2, 32'h11112222);
    @(negedge HCLK);
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rstmid_accept: got %b expected 001", req_ready); end
    cycle();
    req_valid = '0;
    cycle();
    HREADY = 1'b0;
    @(negedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    checks++; if ({HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, rsp_valid, rsp_rdata, rsp_err} !== '0) begin errors++; $display("FAIL rstmid_async: got sel %b addr %h trans %b wr %b size %h wdata %h rv %b rd %h err %b expected all 0", HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, rsp_valid, rsp_rdata, rsp_err); end
    repeat (2) cycle();
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      checks++; if (rsp_valid !== '0 || HTRANS !== 2'b00) begin errors++; $display("FAIL rstmid_quiet[%0d]: got valid %b trans %b expected 000 00", i, rsp_valid, HTRANS); end
      cycle();
    end
    set_cmd(0, 32'h0, 1'b0, 3'd2, '0);
    set_cmd(1, 32'h0, 1'b0, 3'd2, '0);
    @(negedge HCLK);
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rstmid_ptr: got %b expected 001", req_ready); end
    req_valid = '0;
    cycle();
    xfer(1, 32'h40, 1'b0, 3'd2, '0, 0, 1'b0, 32'hCAFEF00D, lat, rv, rd, re);
    checks++; if (rv !== 3'b010 || rd !== 32'hCAFEF00D || re !== 1'b0 || lat !== 3) begin errors++; $display("FAIL rstmid_after: got valid %b rdata %h err %b lat %0d expected 010 cafef00d 0 3", rv, rd, re, lat); end
  endtask

  task automatic test_random(input int ncyc);
    int acc_idx, win, best, d, ptr, exp_owner, dcnt, dwait;
    bit exp_pend, exp_err, exp_rd_chk, dph, dph_next, derr, legal;
    logic [DW-1:0] exp_rd;
    logic [NREQ-1:0] ev;
    acc_idx = -1; ptr = NREQ - 1; exp_pend = 0; exp_owner = 0; exp_err = 0;
    exp_rd_chk = 0; exp_rd = '0; dph = 0; dph_next = 0; dcnt = 0; dwait = 0; derr = 0;
    mq.delete();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int i = 0; i < NREQ; i++) begin
      mpend[i] = 0;
      mcmd[i]  = '{owner: i, addr: '0, wr: 0, sz: 3'd0, wd: '0};
    end
    clear_reqs();
    HRESETn = 1'b0;
    repeat (2) cycle();
    HRESETn = 1'b1;
    for (int c = 0; c < ncyc + 100; c++) begin
      if (acc_idx >= 0) mpend[acc_idx] = 0;
      acc_idx = -1;
      for (int i = 0; i < NREQ; i++) begin
        if (mpend[i] && $urandom_range(0, 15) == 0) mpend[i] = 0;
        else if (!mpend[i] && c < ncyc && $urandom_range(0, 2) == 0) begin
          mpend[i]     = 1;
          mcmd[i].addr = AW'($urandom_range(0, 63));
          mcmd[i].wr   = 1'($urandom_range(0, 1));
          mcmd[i].sz   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
          mcmd[i].wd   = $urandom;
        end
        req_valid[i]          = mpend[i];
        req_addr[i*AW +: AW]  = mcmd[i].addr;
        req_write[i]          = mcmd[i].wr;
        req_size[i*3 +: 3]    = mcmd[i].sz;
        req_wdata[i*DW +: DW] = mcmd[i].wd;
      end
      if (dph_next) begin
        dph = 1; dph_next = 0; dcnt = 0;
        dwait = $urandom_range(0, 2);
        derr  = ($urandom_range(0, 4) == 0);
      end
      if (dph) begin
        if (dcnt < dwait) begin HREADY = 1'b0; HRESP = 1'b0; end
        else if (derr && dcnt == dwait) begin HREADY = 1'b0; HRESP = 1'b1; end
        else begin HREADY = 1'b1; HRESP = derr; end
        HRDATA = mem[mq[0].addr[5:2]];
      end else begin
        HREADY = ($urandom_range(0, 3) != 0);
        HRESP  = 1'b0;
        HRDATA = $urandom;
      end

      @(negedge HCLK);
      ev = '0;
      if (exp_pend) ev[exp_owner] = 1'b1;
      checks++; if (rsp_valid !== ev) begin errors++; $display("FAIL rand_rsp_valid: cyc %0d got %b expected %b", c, rsp_valid, ev); end
      if (exp_pend) begin
        checks++; if (rsp_err !== exp_err) begin errors++; $display("FAIL rand_rsp_err: cyc %0d got %b expected %b", c, rsp_err, exp_err); end
        if (exp_rd_chk) begin
          checks++; if (rsp_rdata !== exp_rd) begin errors++; $display("FAIL rand_rsp_rdata: cyc %0d got %h expected %h", c, rsp_rdata, exp_rd); end
        end
      end
      exp_pend = 0;

      // Winner = valid requester nearest after the last grant (or lowest index).
      win = -1; best = NREQ;
      if (mq.size() == 0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (mpend[i]) begin
`ifdef AHB_ARB_FIXED_PRIO_EN
            d = i;
`else
            d = (i - ptr - 1 + 2 * NREQ) % NREQ;
`endif
            if (d < best) begin best = d; win = i; end
          end
        end
      end
      ev = '0;
      if (win >= 0) ev[win] = 1'b1;
      checks++; if (req_ready !== ev) begin errors++; $display("FAIL rand_req_ready: cyc %0d got %b expected %b", c, req_ready, ev); end

      if (HSEL === 1'b1 && HTRANS === 2'b10) begin
        checks++;
        if (mq.size() == 0) begin errors++; $display("FAIL rand_addr_phase: cyc %0d got unexpected transfer addr %h expected none", c, HADDR); end
        else begin
          if (HADDR !== mq[0].addr || HWRITE !== mq[0].wr || HSIZE !== mq[0].sz) begin errors++; $display("FAIL rand_addr_phase: cyc %0d got addr %h wr %b size %h expected %h %b %h", c, HADDR, HWRITE, HSIZE, mq[0].addr, mq[0].wr, mq[0].sz); end
          if (HREADY) dph_next = 1;
        end
      end

      if (dph) begin
        if (HREADY) begin
          if (mq[0].wr) begin
            checks++; if (HWDATA !== mq[0].wd) begin errors++; $display("FAIL rand_hwdata: cyc %0d got %h expected %h", c, HWDATA, mq[0].wd); end
            mem[mq[0].addr[5:2]] = mq[0].wd;
          end
          exp_pend = 1; exp_owner = mq[0].owner; exp_err = derr; exp_rd_chk = !derr;
          exp_rd = mq[0].wr ? '0 : mem[mq[0].addr[5:2]];
          void'(mq.pop_front());
          dph = 0;
        end else begin
          dcnt++;
        end
      end

      if (win >= 0) begin
        acc_idx = win;
        ptr = win;
        legal = (mcmd[win].sz <= 3'd2) && ((mcmd[win].addr % (32'd1 << mcmd[win].sz)) == 0);
        if (legal) mq.push_back(mcmd[win]);
        else begin exp_pend = 1; exp_owner = win; exp_err = 1; exp_rd_chk = 0; end
      end
      @(posedge HCLK);
      #1;
    end
    clear_reqs();
    HREADY = 1'b1;
    HRESP  = 1'b0;
    checks++; if (mq.size() != 0 || exp_pend) begin errors++; $display("FAIL rand_drain: got %0d transfers outstanding expected 0", mq.size() + int'(exp_pend)); end
  endtask

  initial begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    clear_reqs();
    test_reset();
    test_single_write();
    test_read_wait();
    test_contention();
    test_misaligned();
    test_slave_error();
    test_reset_mid();
    test_random(2000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
